// File: rtl/unpacked_pipeline_slice.sv
// Valid/ready retiming slice for an unpacked lane array, with synchronous flush and live occupancy.
// Each stage is either a two-entry skid buffer (registered ready) or a single forward register.
module unpacked_pipeline_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 16,
    parameter int STAGES     = 2,
    parameter int MODE       = 0,
    parameter int OCC_WIDTH  = (STAGES > 0) ? $clog2(2 * STAGES + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data [IN_SIZE],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [IN_SIZE],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OCC_WIDTH-1:0]  occupancy
);
    typedef logic [IN_SIZE-1:0][DATA_WIDTH-1:0] beat_t;

    // Index s is the boundary feeding stage s; index STAGES is the slice output.
    logic [STAGES:0][IN_SIZE-1:0][DATA_WIDTH-1:0] bus;
    logic [STAGES:0]                              vld;
    logic [STAGES:0]                              rdy;

    for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
        assign bus[0][i]   = in_data[i];
        assign out_data[i] = bus[STAGES][i];
    end

    assign vld[0]      = in_valid;
    assign rdy[STAGES] = out_ready;
    assign out_valid   = vld[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (MODE == 0) begin : g_skid
            logic  main_v, skid_v, rdy_q, take;
            logic  main_v_nxt, skid_v_nxt;
            beat_t main_d, skid_d, main_d_nxt, skid_d_nxt;

            assign take = vld[s] && rdy_q;

            always_comb begin
                main_v_nxt = main_v;
                main_d_nxt = main_d;
                skid_v_nxt = skid_v;
                skid_d_nxt = skid_d;
                if (!main_v || rdy[s+1]) begin
                    if (skid_v) begin
                        main_v_nxt = 1'b1;
                        main_d_nxt = skid_d;
                        skid_v_nxt = 1'b0;
                    end else begin
                        main_v_nxt = take;
                        if (take) main_d_nxt = bus[s];
                    end
                end else if (take) begin
                    skid_v_nxt = 1'b1;
                    skid_d_nxt = bus[s];
                end
                if (flush) begin
                    main_v_nxt = 1'b0;
                    skid_v_nxt = 1'b0;
                end
            end

            // Ready is a flop of "skid will be empty" so out_ready never reaches in_ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                    rdy_q  <= 1'b0;
                end else begin
                    main_v <= main_v_nxt;
                    skid_v <= skid_v_nxt;
                    rdy_q  <= !skid_v_nxt;
                end
            end

            always_ff @(posedge clk) begin
                main_d <= main_d_nxt;
                skid_d <= skid_d_nxt;
            end

            assign vld[s+1] = main_v;
            assign bus[s+1] = main_d;
            assign rdy[s]   = rdy_q;
        end else begin : g_fwd
            logic  val_q;
            beat_t dat_q;

            assign rdy[s] = !val_q || rdy[s+1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_q <= 1'b0;
                end else if (flush) begin
                    val_q <= 1'b0;
                end else if (rdy[s]) begin
                    val_q <= vld[s];
                end
            end

            always_ff @(posedge clk) begin
                if (rdy[s] && vld[s]) dat_q <= bus[s];
            end

            assign vld[s+1] = val_q;
            assign bus[s+1] = dat_q;
        end
    end

    if (STAGES == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk, rst, flush};
        assign in_ready    = rdy[0];
        assign occupancy   = '0;
    end else begin : g_occ
        logic                 accept, emit;
        logic [OCC_WIDTH-1:0] occ_q;

        // Blocking ready during flush keeps a beat from slipping in as everything is dropped.
        assign in_ready = rdy[0] && !flush;
        assign accept   = in_valid && in_ready;
        assign emit     = out_valid && out_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q <= '0;
            end else if (flush) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_q + OCC_WIDTH'(accept) - OCC_WIDTH'(emit);
            end
        end

        assign occupancy = occ_q;
    end
endmodule
